// File: rtl/sreg_rx_if.sv
// Bundle of the serial-in link and the parallel-word handshake of sreg_rx.
// The master side drives the strobes and ack/clr_ovr, and the slave side (the
// receiver) drives the assembled word and its status.
interface sreg_rx_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 5
);
    logic             sft;
    logic             sin;
    logic             sync;
    logic             ack;
    logic             clr_ovr;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             overrun;
    logic [CW-1:0]    bcnt;

    modport master (
        output sft, sin, sync, ack, clr_ovr,
        input  dout, dout_valid, overrun, bcnt
    );

    modport slave (
        input  sft, sin, sync, ack, clr_ovr,
        output dout, dout_valid, overrun, bcnt
    );
endinterface

// File: rtl/sreg_rx.sv
// Serial-in, parallel-out word receiver for the MSB-first left-shift link.
// It collects WIDTH bits on shift strobes and presents each finished word with
// a valid/ack handshake. A word that completes while the previous one is still
// unacknowledged is dropped, and the sticky overrun flag is raised.
//
// Handshake: dout is meaningful while dout_valid=1. The consumer takes the word
// by raising ack on any edge where dout_valid=1, and dout_valid drops on that
// edge unless a new word completes on the same edge. If it does, the new word
// replaces the old one and dout_valid stays high. An ack while dout_valid=0 has
// no effect. dout is never cleared by ack; it only changes when a word is
// delivered or on reset.
module sreg_rx #(
    parameter int WIDTH = 16,
    parameter int CW    = 5
) (
    input  logic       clk,
    input  logic       reset,
    sreg_rx_if.slave   bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hs_state_t;

    hs_state_t        state, state_next;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shifted;
    logic [WIDTH-1:0] dout_q;
    logic [CW-1:0]    bcnt_q;
    logic             overrun_q;
    logic             wc;
    logic             load;
    logic             drop;

    // Word the shift register would hold after this strobe, and the
    // completion condition. A sync never completes a word.
    assign sr_shifted = {sr[WIDTH-2:0], bus.sin};
    assign wc         = bus.sft && !bus.sync && (bcnt_q == CW'(WIDTH - 1));

    // Shift register and bit counter. A sync restarts the frame, and a sync
    // that arrives with a strobe keeps its bit as the first bit of the new word.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr     <= '0;
            bcnt_q <= '0;
        end else if (bus.sync) begin
            if (bus.sft) begin
                sr     <= {{(WIDTH-1){1'b0}}, bus.sin};
                bcnt_q <= CW'(1);
            end else begin
                sr     <= '0;
                bcnt_q <= '0;
            end
        end else if (bus.sft) begin
            sr     <= sr_shifted;
            bcnt_q <= wc ? '0 : bcnt_q + CW'(1);
        end
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next handshake state, and whether a finished word is delivered or dropped.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            EMPTY: begin
                if (wc) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (wc) begin
                    if (bus.ack) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (bus.ack) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Output word register. It is loaded only with a delivered word.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
        end else if (load) begin
            dout_q <= sr_shifted;
        end
    end

    // Sticky overrun flag. A new drop takes priority over clr_ovr.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (bus.clr_ovr) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = (state == FULL);
    assign bus.overrun    = overrun_q;
    assign bus.bcnt       = bcnt_q;
endmodule

// File: tb/tb_sreg_rx.sv
// Directed and randomized bench for sreg_rx, with a word-level reference model.
module tb_sreg_rx;
    localparam int W  = 16;
    localparam int CW = 5;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sreg_rx_if #(.WIDTH(W), .CW(CW)) bus ();

    sreg_rx #(.WIDTH(W), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: number of bits collected, their value, the delivered
    // word, and the status flags
    int           m_cnt;
    int unsigned  m_acc;
    logic [W-1:0] m_dout;
    logic         m_valid;
    logic         m_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic d,
                              input logic sy, input logic a, input logic c);
        int unsigned word;
        logic        done;
        logic        lost;
        if (r) begin
            m_cnt = 0; m_acc = 0; m_dout = '0; m_valid = 1'b0; m_ovr = 1'b0;
            return;
        end
        lost = 1'b0;
        done = 1'b0;
        word = (m_acc * 2 + 32'(d)) % (32'd1 << W);
        if (sy) begin
            m_cnt = s ? 1 : 0;
            m_acc = s ? 32'(d) : 0;
        end else if (s) begin
            m_cnt = m_cnt + 1;
            m_acc = word;
            if (m_cnt == W) begin
                done  = 1'b1;
                m_cnt = 0;
                m_acc = 0;
            end
        end
        if (done) begin
            if (!m_valid || a) begin
                m_dout  = W'(word);
                m_valid = 1'b1;
            end else begin
                lost = 1'b1;
            end
        end else if (a) begin
            m_valid = 1'b0;
        end
        if (lost) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
    endtask

    // driver: apply one cycle of inputs, clock it, then compare to the model
    task automatic drive(input logic r, input logic s, input logic d,
                         input logic sy, input logic a, input logic c);
        reset = r; bus.sft = s; bus.sin = d; bus.sync = sy; bus.ack = a; bus.clr_ovr = c;
        model_step(r, s, d, sy, a, c);
        @(posedge clk);
        #1;
        chk("dout", 32'(bus.dout), 32'(m_dout));
        chk("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
        chk("bcnt", 32'(bus.bcnt), 32'(m_cnt));
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    // send bits [W-1-first .. W-1-last] of word MSB-first, gap clocks per bit
    task automatic send_bits(input logic [W-1:0] word, input int first, input int last,
                             input int gap, input logic ack_last);
        for (int i = first; i <= last; i++) begin
            for (int g = 1; g < gap; g++) idle();
            drive(0, 1, word[W-1-i], 0, ack_last && (i == last), 0);
        end
    endtask

    task automatic send_word(input logic [W-1:0] word, input int gap, input logic ack_last);
        send_bits(word, 0, W - 1, gap, ack_last);
    endtask

    initial begin
        reset = 1'b1; bus.sft = 0; bus.sin = 0; bus.sync = 0; bus.ack = 0; bus.clr_ovr = 0;
        m_cnt = 0; m_acc = 0; m_dout = '0; m_valid = 0; m_ovr = 0;

        // reset state
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 1, 1);
        chk("rst_dout", 32'(bus.dout), 32'h0);
        chk("rst_valid", 32'(bus.dout_valid), 32'h0);
        idle();

        // 1: first word, one cycle of latency after the final strobe
        send_bits(16'hA5C3, 0, 14, 1, 0);
        chk("t1_valid_before", 32'(bus.dout_valid), 32'h0);
        send_bits(16'hA5C3, 15, 15, 1, 0);
        chk("t1_dout", 32'(bus.dout), 32'hA5C3);
        chk("t1_valid", 32'(bus.dout_valid), 32'h1);
        chk("t1_bcnt", 32'(bus.bcnt), 32'h0);
        chk("t1_ovr", 32'(bus.overrun), 32'h0);

        // 2: ack empties, dout held; spaced strobes
        drive(0, 0, 0, 0, 1, 0);
        chk("t2_valid", 32'(bus.dout_valid), 32'h0);
        chk("t2_dout_held", 32'(bus.dout), 32'hA5C3);
        drive(0, 0, 0, 0, 1, 0);
        send_word(16'h0001, 3, 0);
        chk("t2_dout", 32'(bus.dout), 32'h0001);
        drive(0, 0, 0, 0, 1, 0);

        // 3: overrun keeps the old word; clr_ovr clears only the flag
        send_word(16'h1234, 1, 0);
        send_word(16'hFFFF, 2, 0);
        chk("t3_dout", 32'(bus.dout), 32'h1234);
        chk("t3_valid", 32'(bus.dout_valid), 32'h1);
        chk("t3_ovr", 32'(bus.overrun), 32'h1);
        drive(0, 0, 0, 0, 0, 1);
        chk("t3_clr", 32'(bus.overrun), 32'h0);
        chk("t3_valid_kept", 32'(bus.dout_valid), 32'h1);
        drive(0, 0, 0, 0, 1, 0);

        // 4: ack coinciding with completion delivers without overrun
        send_word(16'h8000, 1, 0);
        send_word(16'h00FF, 1, 1);
        chk("t4_dout", 32'(bus.dout), 32'h00FF);
        chk("t4_valid", 32'(bus.dout_valid), 32'h1);
        chk("t4_ovr", 32'(bus.overrun), 32'h0);
        drive(0, 0, 0, 0, 1, 0);

        // 5: resync with a strobe, then resync without
        send_bits(16'h5555, 0, 6, 1, 0);
        drive(0, 1, 1, 1, 0, 0);
        chk("t5_bcnt_sync", 32'(bus.bcnt), 32'h1);
        send_bits(16'hBEEF, 1, 15, 1, 0);
        chk("t5_dout", 32'(bus.dout), 32'hBEEF);
        drive(0, 0, 0, 0, 1, 0);
        send_bits(16'h3C3C, 0, 8, 1, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk("t5_bcnt_zero", 32'(bus.bcnt), 32'h0);

        // 6: reset mid-word with status set, then a clean word
        send_word(16'h1111, 1, 0);
        send_word(16'h2222, 1, 0);
        send_bits(16'h3333, 0, 9, 1, 0);
        chk("t6_pre_ovr", 32'(bus.overrun), 32'h1);
        drive(1, 0, 0, 0, 0, 0);
        chk("t6_dout", 32'(bus.dout), 32'h0);
        chk("t6_valid", 32'(bus.dout_valid), 32'h0);
        chk("t6_ovr", 32'(bus.overrun), 32'h0);
        chk("t6_bcnt", 32'(bus.bcnt), 32'h0);
        send_word(16'h5A5A, 1, 0);
        chk("t6_new", 32'(bus.dout), 32'h5A5A);

        // clear-vs-set collision: a new drop wins over clr_ovr
        send_word(16'h0F0F, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        send_bits(16'h7777, 0, 14, 1, 0);
        reset = 0; bus.sft = 1; bus.sin = 1; bus.sync = 0; bus.ack = 0; bus.clr_ovr = 1;
        model_step(0, 1, 1, 0, 0, 1);
        @(posedge clk);
        #1;
        chk("set_wins", 32'(bus.overrun), 32'h1);
        chk("set_wins_dout", 32'(bus.dout), 32'h5A5A ^ 32'h5A5A ^ 32'(m_dout));

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // overall time limit
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
